// File: rtl/gw2a_ddr_rdlvl_if.sv
// rtl/gw2a_ddr_rdlvl_if.sv - controller and IOB signal bundle for the GW2A read-leveling aligner
interface gw2a_ddr_rdlvl_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             busy_o;
  logic             done_o;
  logic             fail_o;
  logic [3:0]       lat_o;
  logic [WIDTH-1:0] slip_o;
  logic             oen_o;
  logic [WIDTH-1:0] d0_o;
  logic [WIDTH-1:0] d1_o;
  logic [WIDTH-1:0] q0_i;
  logic [WIDTH-1:0] q1_i;
  logic [WIDTH-1:0] rd_q0_o;
  logic [WIDTH-1:0] rd_q1_o;

  modport slave (
    input  start_i, q0_i, q1_i,
    output busy_o, done_o, fail_o, lat_o, slip_o, oen_o, d0_o, d1_o, rd_q0_o, rd_q1_o
  );

  modport master (
    output start_i, q0_i, q1_i,
    input  busy_o, done_o, fail_o, lat_o, slip_o, oen_o, d0_o, d1_o, rd_q0_o, rd_q1_o
  );
endinterface

// File: rtl/gw2a_ddr_rdlvl.sv
// rtl/gw2a_ddr_rdlvl.sv - runtime read-leveling and bit-slip aligner for GW2A DDR DQ IOBs
module gw2a_ddr_rdlvl #(
  parameter int         WIDTH    = 8,
  parameter logic [7:0] PATTERN  = 8'b1100_1010,
  parameter int         MAX_WAIT = 15,
  parameter int         RETRIES  = 3
) (
  input  logic PCLK,
  input  logic RESETN,
  gw2a_ddr_rdlvl_if.slave bus
);

  localparam int AW = $clog2(RETRIES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       k;
  logic [1:0]       gcnt;
  logic [3:0]       wcnt;
  logic [AW-1:0]    att;
  logic             busy_r;
  logic             done_r;
  logic             fail_r;
  logic [3:0]       lat_r;
  logic [WIDTH-1:0] slip_r;
  logic             oen_r;
  logic [WIDTH-1:0] d0_r;
  logic [WIDTH-1:0] d1_r;
  logic [WIDTH-1:0] q1_prev;
  logic [WIDTH-1:0] rd_q0_r;
  logic [WIDTH-1:0] rd_q1_r;

  // Only bits 9..1 of the 2-bit-per-cycle capture history take part in matching.
  logic [9:1]       hist [WIDTH];

  logic [WIDTH-1:0] lane_match;
  logic [WIDTH-1:0] lane_slip;
  logic             all_match;
  logic             any_match;
  logic [1:0]       k_next;
  logic [3:0]       wcnt_next;
  logic [AW-1:0]    att_next;

  always_comb begin
    lane_match = '0;
    lane_slip  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_match[i] = (hist[i][9:2] == PATTERN) || (hist[i][8:1] == PATTERN);
      lane_slip[i]  = (hist[i][9:2] != PATTERN) && (hist[i][8:1] == PATTERN);
    end
  end

  assign all_match = &lane_match;
  assign any_match = |lane_match;
  assign k_next    = k + 2'd1;
  assign wcnt_next = wcnt + 4'd1;
  assign att_next  = att + AW'(1);

  always_ff @(posedge PCLK or negedge RESETN) begin
    if (!RESETN) begin
      state  <= IDLE;
      k      <= '0;
      gcnt   <= '0;
      wcnt   <= '0;
      att    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      fail_r <= 1'b0;
      lat_r  <= '0;
      slip_r <= '0;
      oen_r  <= 1'b1;
      d0_r   <= '0;
      d1_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            done_r <= 1'b0;
            fail_r <= 1'b0;
            att    <= '0;
            busy_r <= 1'b1;
            k      <= '0;
            oen_r  <= 1'b0;
            d0_r   <= {WIDTH{PATTERN[0]}};
            d1_r   <= {WIDTH{PATTERN[1]}};
            state  <= SEND;
          end
        end
        SEND: begin
          if (k == 2'd3) begin
            oen_r <= 1'b1;
            d0_r  <= '0;
            d1_r  <= '0;
            wcnt  <= '0;
            state <= WAIT;
          end else begin
            k    <= k_next;
            d0_r <= {WIDTH{PATTERN[{k_next, 1'b0}]}};
            d1_r <= {WIDTH{PATTERN[{k_next, 1'b1}]}};
          end
        end
        WAIT: begin
          wcnt <= wcnt_next;
          if (all_match) begin
            lat_r  <= wcnt_next;
            slip_r <= lane_slip;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (any_match || (wcnt_next == 4'(MAX_WAIT))) begin
            // A partial match means lanes disagree on latency; the attempt is lost.
            att <= att_next;
            if (att_next < AW'(RETRIES)) begin
              gcnt  <= '0;
              state <= GAP;
            end else begin
              fail_r <= 1'b1;
              busy_r <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        GAP: begin
          if (gcnt == 2'd3) begin
            k     <= '0;
            oen_r <= 1'b0;
            d0_r  <= {WIDTH{PATTERN[0]}};
            d1_r  <= {WIDTH{PATTERN[1]}};
            state <= SEND;
          end else begin
            gcnt <= gcnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < WIDTH; i++) begin
        hist[i] <= '0;
      end
      q1_prev <= '0;
      rd_q0_r <= '0;
      rd_q1_r <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        hist[i] <= {bus.q1_i[i], bus.q0_i[i], hist[i][9:3]};
      end
      q1_prev <= bus.q1_i;
      // Slip-1 lanes pair last cycle's Q1 with this cycle's Q0.
      rd_q0_r <= (slip_r & q1_prev)   | (~slip_r & bus.q0_i);
      rd_q1_r <= (slip_r & bus.q0_i)  | (~slip_r & bus.q1_i);
    end
  end

  assign bus.busy_o  = busy_r;
  assign bus.done_o  = done_r;
  assign bus.fail_o  = fail_r;
  assign bus.lat_o   = lat_r;
  assign bus.slip_o  = slip_r;
  assign bus.oen_o   = oen_r;
  assign bus.d0_o    = d0_r;
  assign bus.d1_o    = d1_r;
  assign bus.rd_q0_o = rd_q0_r;
  assign bus.rd_q1_o = rd_q1_r;

endmodule

// File: tb/tb_gw2a_ddr_rdlvl.sv
// tb/tb_gw2a_ddr_rdlvl.sv - loopback bench for gw2a_ddr_rdlvl
module tb_gw2a_ddr_rdlvl;
  localparam int WIDTH = 8;

  logic PCLK = 1'b0;
  logic RESETN;
  always #5 PCLK = ~PCLK;

  gw2a_ddr_rdlvl_if #(.WIDTH(WIDTH)) bus();
  gw2a_ddr_rdlvl #(.WIDTH(WIDTH)) dut (.PCLK(PCLK), .RESETN(RESETN), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Loopback: a slip-0 lane with pipe length L locks at lat L+1; a slip-1 lane
  // uses pipe length L-1 plus one bit so its pattern starts on Q1 in the same cycle.
  logic [WIDTH-1:0] pipe0 [16];
  logic [WIDTH-1:0] pipe1 [16];
  int               lane_len [WIDTH];
  logic [WIDTH-1:0] lane_bit;
  logic             connected;
  logic             ext_mode;
  logic [WIDTH-1:0] ext_q0, ext_q1;
  logic [WIDTH-1:0] lq0, lq1;

  always @(posedge PCLK) begin
    if (!RESETN) begin
      for (int j = 0; j < 16; j++) begin
        pipe0[j] <= '0;
        pipe1[j] <= '0;
      end
    end else begin
      pipe0[0] <= bus.oen_o ? '0 : bus.d0_o;
      pipe1[0] <= bus.oen_o ? '0 : bus.d1_o;
      for (int j = 1; j < 16; j++) begin
        pipe0[j] <= pipe0[j-1];
        pipe1[j] <= pipe1[j-1];
      end
    end
  end

  always_comb begin
    lq0 = '0;
    lq1 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lane_bit[i]) begin
        lq0[i] = pipe1[lane_len[i]][i];
        lq1[i] = pipe0[lane_len[i]-1][i];
      end else begin
        lq0[i] = pipe0[lane_len[i]-1][i];
        lq1[i] = pipe1[lane_len[i]-1][i];
      end
    end
  end

  assign bus.q0_i = ext_mode ? ext_q0 : (connected ? lq0 : '0);
  assign bus.q1_i = ext_mode ? ext_q1 : (connected ? lq1 : '0);

  task automatic set_lanes(input int len, input int len7);
    for (int i = 0; i < WIDTH; i++) lane_len[i] = len;
    lane_len[7] = len7;
    lane_bit = '0;
  endtask

  task automatic do_train(input int extra_at, output int busy_cyc, output int oen_cyc);
    @(negedge PCLK);
    bus.start_i = 1'b1;
    @(posedge PCLK);
    #1 bus.start_i = 1'b0;
    busy_cyc = 0;
    oen_cyc = 0;
    for (int n = 0; n < 300; n++) begin
      if (!bus.busy_o) break;
      busy_cyc++;
      if (!bus.oen_o) oen_cyc++;
      if (n == extra_at) begin
        @(negedge PCLK);
        bus.start_i = 1'b1;
        @(posedge PCLK);
        #1 bus.start_i = 1'b0;
      end else begin
        @(posedge PCLK);
        #1;
      end
    end
    if (bus.busy_o) busy_cyc = -1;
  endtask

  task automatic test_reset;
    RESETN = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    RESETN = 1'b1;
    @(posedge PCLK);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL reset_fail got %b expected 0", bus.fail_o); end
    checks++; if (bus.lat_o !== 4'd0) begin errors++; $display("FAIL reset_lat got %0d expected 0", bus.lat_o); end
    checks++; if (bus.slip_o !== 8'h00) begin errors++; $display("FAIL reset_slip got %h expected 00", bus.slip_o); end
    checks++; if (bus.oen_o !== 1'b1) begin errors++; $display("FAIL reset_oen got %b expected 1", bus.oen_o); end
    checks++; if ({bus.d0_o, bus.d1_o} !== 16'h0000) begin errors++; $display("FAIL reset_d got %h expected 0000", {bus.d0_o, bus.d1_o}); end
    checks++; if ({bus.rd_q0_o, bus.rd_q1_o} !== 16'h0000) begin errors++; $display("FAIL reset_rd got %h expected 0000", {bus.rd_q0_o, bus.rd_q1_o}); end
  endtask

  task automatic test_lock_slip0;
    int bc, oc;
    set_lanes(2, 2);
    do_train(-1, bc, oc);
    checks++; if (bc !== 7) begin errors++; $display("FAIL lock_busy_cycles got %0d expected 7", bc); end
    checks++; if (oc !== 4) begin errors++; $display("FAIL lock_oen_cycles got %0d expected 4", oc); end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL lock_done got %b expected 1", bus.done_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL lock_fail got %b expected 0", bus.fail_o); end
    checks++; if (bus.lat_o !== 4'd3) begin errors++; $display("FAIL lock_lat got %0d expected 3", bus.lat_o); end
    checks++; if (bus.slip_o !== 8'h00) begin errors++; $display("FAIL lock_slip got %h expected 00", bus.slip_o); end
  endtask

  task automatic test_slip_mix;
    int bc, oc;
    logic [7:0] a0 [5];
    logic [7:0] a1 [5];
    logic [7:0] s;
    set_lanes(4, 4);
    lane_bit = 8'b0010_0101;
    for (int i = 0; i < WIDTH; i++) if (lane_bit[i]) lane_len[i] = 3;
    do_train(-1, bc, oc);
    checks++; if (bc !== 9) begin errors++; $display("FAIL mix_busy_cycles got %0d expected 9", bc); end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL mix_done got %b expected 1", bus.done_o); end
    checks++; if (bus.lat_o !== 4'd5) begin errors++; $display("FAIL mix_lat got %0d expected 5", bus.lat_o); end
    checks++; if (bus.slip_o !== 8'b0010_0101) begin errors++; $display("FAIL mix_slip got %h expected 25", bus.slip_o); end
    a0 = '{8'h00, 8'h5A, 8'h3C, 8'h00, 8'h00};
    a1 = '{8'h00, 8'h3C, 8'h5A, 8'h00, 8'h00};
    s = 8'b0010_0101;
    for (int t = 0; t < 4; t++) begin
      @(negedge PCLK);
      ext_mode = 1'b1;
      ext_q0 = (s & a1[t]) | (~s & a0[t]);
      ext_q1 = (s & a0[t+1]) | (~s & a1[t]);
      @(posedge PCLK);
      #1;
      if (t >= 1) begin
        checks++; if (bus.rd_q0_o !== a0[t]) begin errors++; $display("FAIL stream_q0 t=%0d got %h expected %h", t, bus.rd_q0_o, a0[t]); end
        checks++; if (bus.rd_q1_o !== a1[t]) begin errors++; $display("FAIL stream_q1 t=%0d got %h expected %h", t, bus.rd_q1_o, a1[t]); end
      end
    end
    @(negedge PCLK);
    ext_mode = 1'b0;
    set_lanes(2, 2);
  endtask

  task automatic test_fail_disconnected;
    int bc, oc;
    connected = 1'b0;
    do_train(-1, bc, oc);
    checks++; if (bc !== 65) begin errors++; $display("FAIL disc_busy_cycles got %0d expected 65", bc); end
    checks++; if (oc !== 12) begin errors++; $display("FAIL disc_oen_cycles got %0d expected 12", oc); end
    checks++; if (bus.fail_o !== 1'b1) begin errors++; $display("FAIL disc_fail got %b expected 1", bus.fail_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL disc_done got %b expected 0", bus.done_o); end
    checks++; if (bus.lat_o !== 4'd5) begin errors++; $display("FAIL disc_lat_kept got %0d expected 5", bus.lat_o); end
    checks++; if (bus.slip_o !== 8'h25) begin errors++; $display("FAIL disc_slip_kept got %h expected 25", bus.slip_o); end
    connected = 1'b1;
  endtask

  task automatic test_lane_skew;
    int bc, oc;
    set_lanes(2, 3);
    do_train(-1, bc, oc);
    checks++; if (bc !== 29) begin errors++; $display("FAIL skew_busy_cycles got %0d expected 29", bc); end
    checks++; if (oc !== 12) begin errors++; $display("FAIL skew_oen_cycles got %0d expected 12", oc); end
    checks++; if (bus.fail_o !== 1'b1) begin errors++; $display("FAIL skew_fail got %b expected 1", bus.fail_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL skew_done got %b expected 0", bus.done_o); end
    checks++; if (bus.lat_o !== 4'd5) begin errors++; $display("FAIL skew_lat_kept got %0d expected 5", bus.lat_o); end
    set_lanes(2, 2);
  endtask

  task automatic test_reset_mid_send;
    int bc, oc;
    set_lanes(2, 2);
    @(negedge PCLK);
    bus.start_i = 1'b1;
    @(posedge PCLK);
    #1 bus.start_i = 1'b0;
    @(posedge PCLK);
    #1;
    checks++; if (bus.oen_o !== 1'b0) begin errors++; $display("FAIL rst_send_oen got %b expected 0", bus.oen_o); end
    #2 RESETN = 1'b0;
    #1;
    checks++; if (bus.oen_o !== 1'b1) begin errors++; $display("FAIL rst_async_oen got %b expected 1", bus.oen_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b expected 0", bus.busy_o); end
    checks++; if ({bus.d0_o, bus.d1_o} !== 16'h0000) begin errors++; $display("FAIL rst_async_d got %h expected 0000", {bus.d0_o, bus.d1_o}); end
    checks++; if (bus.lat_o !== 4'd0) begin errors++; $display("FAIL rst_async_lat got %0d expected 0", bus.lat_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL rst_async_fail got %b expected 0", bus.fail_o); end
    @(negedge PCLK);
    RESETN = 1'b1;
    do_train(-1, bc, oc);
    checks++; if (bc !== 7) begin errors++; $display("FAIL rst_retrain_cycles got %0d expected 7", bc); end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL rst_retrain_done got %b expected 1", bus.done_o); end
    checks++; if (bus.lat_o !== 4'd3) begin errors++; $display("FAIL rst_retrain_lat got %0d expected 3", bus.lat_o); end
  endtask

  task automatic test_start_ignored;
    int bc, oc;
    set_lanes(2, 2);
    do_train(5, bc, oc);
    checks++; if (bc !== 7) begin errors++; $display("FAIL ign_busy_cycles got %0d expected 7", bc); end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL ign_done got %b expected 1", bus.done_o); end
    checks++; if (bus.lat_o !== 4'd3) begin errors++; $display("FAIL ign_lat got %0d expected 3", bus.lat_o); end
    @(negedge PCLK);
    bus.start_i = 1'b1;
    @(posedge PCLK);
    #1 bus.start_i = 1'b0;
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL restart_done_clear got %b expected 0", bus.done_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL restart_busy got %b expected 1", bus.busy_o); end
    for (int n = 0; n < 100; n++) begin
      if (!bus.busy_o) break;
      @(posedge PCLK);
      #1;
    end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL restart_done got %b expected 1", bus.done_o); end
  endtask

  initial begin
    bus.start_i = 1'b0;
    RESETN = 1'b0;
    connected = 1'b1;
    ext_mode = 1'b0;
    ext_q0 = '0;
    ext_q1 = '0;
    set_lanes(2, 2);
    test_reset();
    test_lock_slip0();
    test_slip_mix();
    test_fail_disconnected();
    test_lane_skew();
    test_reset_mid_send();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
